cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Instruction sequencer for the 4-bit lab CPU, sitting between program memory, the microcode ROM and the datapath.
- Owns the program counter, the two-phase fetch/execute cycle, the fetched instruction register and the carry/zero flags register.
- Builds the 7-bit microcode ROM address each cycle.
- Applies the sequencing bits of the returned 13-bit control word; the remaining control bits pass through to the datapath.

## Interface
Parameters:
- PC_W, 12, program counter / program memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 allows new instruction fetches.
- prog_addr  out  PC_W  program memory address (= pc).
- prog_req  out  1  fetch request.
- prog_ack  in  1  program memory data valid; one-cycle pulse.
- prog_data  in  8  instruction byte: [7:4] opcode, [3:0] operand.
- rom_en  out  1  microcode ROM enable.
- rom_addr  out  7  {opcode[3:0], carry, zero, phase}.
- ctrl  in  13  control word from ROM. Bits used here: [12] incPC, [11] loadPC, [9] loadFlags.
- jump_addr  in  PC_W  PC load value from datapath.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero.
- operand  out  4  latched operand.
- phase  out  1  0 = fetch, 1 = execute.
- flags  out  2  {carry, zero}.

## Operation
States:
- IDLE
- FETCH (phase 0)
- EXEC (phase 1)
- STEP_WAIT (only with the macro)

Transitions:
- IDLE: prog_req=0, rom_en=0. Moves to FETCH when run=1.
- FETCH:
  - prog_req=1 and rom_en=1; rom_addr uses phase 0.
  - prog_req stays high until prog_ack; run falling during FETCH does not drop the request.
  - On the cycle prog_ack=1: latch prog_data into the instruction register; if ctrl[12], pc <= pc+1; go to EXEC.
- EXEC:
  - rom_en=1, rom_addr={opcode, carry, zero, 1}. Lasts exactly one cycle.
  - On exit:
    - if ctrl[11], pc <= jump_addr;
    - else if ctrl[12], pc <= pc+1;
    - if ctrl[9], flags <= {alu_carry, alu_zero}.
  - Next state is FETCH if run=1, else IDLE.

Rules:
- PC arithmetic is modulo 2^PC_W: 0xFFF+1 wraps to 0x000.
- loadPC has priority over incPC when both are set.
- Flags change only in EXEC with loadFlags=1. A prog_ack outside FETCH is ignored.

## Timing
- Reset (async, immediate): pc=0, state=IDLE, phase=0, instruction register=0, operand=0, flags=00, prog_req=0, rom_en=0, rom_addr=0. Asserting rst_n mid-FETCH drops prog_req in the same instant.
- First fetch: prog_req rises on the first edge after rst_n=1 with run=1.
- Instruction length: (wait cycles + 1) FETCH + 1 EXEC. With zero-wait memory (ack in the first request cycle), 2 cycles per instruction.
- Updates: pc, flags and the instruction register update on the clock edge ending their state. rom_addr and phase are registered state decodes, valid from the start of each state.
- Back-to-back: EXEC goes straight to FETCH with no bubble; prog_addr shows the updated pc in that first FETCH cycle.

## Configuration
- SINGLE_STEP_EN defined:
  - Adds input step (1 bit).
  - EXEC always exits to STEP_WAIT (prog_req=0, rom_en=0, phase=0).
  - STEP_WAIT goes to FETCH on a step=1 cycle when run=1; exactly one instruction per step pulse.
  - step held high steps once per instruction.
- SINGLE_STEP_EN undefined: no step port, no STEP_WAIT; EXEC goes to FETCH or IDLE as above.

## Test plan
- Reset/idle: rst_n low then high with run=0 for 10 cycles -> pc=0x000, prog_req=0, rom_en=0, flags=00 throughout.
- Zero-wait fetch: run=1, ack same cycle, prog_data=0x75, ctrl=0x1008 in fetch -> operand=5 and pc=0x001 after 1 cycle; rom_addr=0b0111001 in EXEC; next prog_req at pc=0x001.
- Wait states: ack after 3 cycles -> prog_req held 3 cycles; rom_addr stays at phase 0; pc unchanged until the ack edge.
- Jump priority: EXEC with ctrl[12:11]=11, jump_addr=0x0A3 -> pc=0x0A3. Wrap: pc=0xFFF, incPC -> 0x000.
- Flags: EXEC with ctrl[9]=1, alu_carry=1, alu_zero=0 -> flags=10 and the next EXEC rom_addr[2:1]=10. ctrl[9]=0 -> flags hold.
- Mid-fetch reset and step: rst_n low during FETCH -> prog_req=0 immediately. With SINGLE_STEP_EN, step pulses 3 times -> pc advances 3 and never fetches without a step.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: PC, fetch/execute sequencing, instruction and flag registers for the 4-bit lab CPU.
// Optional feature: define SINGLE_STEP_EN to add the step input and the STEP_WAIT state.
module cpu_sequencer #(
   parameter int PC_W = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
`ifdef SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] prog_addr,
   output logic            prog_req,
   input  logic            prog_ack,
   input  logic [7:0]      prog_data,
   output logic            rom_en,
   output logic [6:0]      rom_addr,
   input  logic [12:0]     ctrl,
   input  logic [PC_W-1:0] jump_addr,
   input  logic            alu_carry,
   input  logic            alu_zero,
   output logic [3:0]      operand,
   output logic            phase,
   output logic [1:0]      flags
);
`ifdef SINGLE_STEP_EN
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, STEP_WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif
   state_t state, state_n;
   logic [PC_W-1:0] pc, pc_n;
   logic [7:0] ir, ir_n;
   logic [1:0] flags_n;
   logic unused_ctrl;
   assign unused_ctrl = ^{ctrl[10], ctrl[8:0]};
   assign prog_addr = pc;
   assign operand = ir[3:0];
   // Next state plus the pc/instruction/flag values committed at the end of this cycle
   always_comb begin
      state_n = state;
      pc_n = pc;
      ir_n = ir;
      flags_n = flags;
      case (state)
         IDLE: state_n = run ? FETCH : IDLE;
         FETCH: if (prog_ack) begin
            state_n = EXEC;
            ir_n = prog_data;
            pc_n = ctrl[12] ? pc + PC_W'(1) : pc;
         end
         EXEC: begin
`ifdef SINGLE_STEP_EN
            state_n = STEP_WAIT;
`else
            state_n = run ? FETCH : IDLE;
`endif
            pc_n = ctrl[11] ? jump_addr : ctrl[12] ? pc + PC_W'(1) : pc;
            flags_n = ctrl[9] ? {alu_carry, alu_zero} : flags;
         end
`ifdef SINGLE_STEP_EN
         STEP_WAIT: state_n = (step && run) ? FETCH : STEP_WAIT;
`endif
         default: state_n = IDLE;
      endcase
   end
   // State, architectural registers and outputs decoded from the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= '0;
         ir <= '0;
         flags <= '0;
         prog_req <= 1'b0;
         rom_en <= 1'b0;
         phase <= 1'b0;
         rom_addr <= '0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         ir <= ir_n;
         flags <= flags_n;
         prog_req <= state_n == FETCH;
         rom_en <= state_n == FETCH || state_n == EXEC;
         phase <= state_n == EXEC;
         rom_addr <= {ir_n[7:4], flags_n, state_n == EXEC};
      end
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer in its default build.
module tb_cpu_sequencer;
   localparam int PC_W = 12;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [3:0]      opr;
      logic [6:0]      ra;
      logic [1:0]      fl;
   } exp_t;
   logic clk = 0, rst_n = 0, run = 0, prog_ack = 0, alu_carry = 0, alu_zero = 0;
   logic [7:0] prog_data = 0;
   logic [12:0] ctrl = 0;
   logic [PC_W-1:0] jump_addr = 0;
   logic [PC_W-1:0] prog_addr;
   logic prog_req, rom_en, phase;
   logic [6:0] rom_addr;
   logic [3:0] operand;
   logic [1:0] flags;
   int passed = 0, total = 0;
   logic [PC_W-1:0] mpc = 0;
   logic [1:0] mflags = 0;
   exp_t sb[$];

   cpu_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .prog_addr(prog_addr), .prog_req(prog_req),
      .prog_ack(prog_ack), .prog_data(prog_data), .rom_en(rom_en), .rom_addr(rom_addr),
      .ctrl(ctrl), .jump_addr(jump_addr), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .operand(operand), .phase(phase), .flags(flags)
   );

   always #5 clk = ~clk;

   // Entered at a negedge with the DUT in FETCH; leaves at a negedge with the DUT in FETCH (run=1)
   task automatic do_instr(input logic [7:0] d, input int waits, input logic [12:0] cf, input logic [12:0] ce,
                           input logic [PC_W-1:0] ja, input logic ac, input logic az, input logic noise);
      exp_t e;
      total++;
      if ({prog_req, rom_en, phase, rom_addr[0], prog_addr} !== {4'b1100, mpc})
         $display("FAIL fetch_entry got req/en/ph/ra0=%b%b%b%b pc=%h want 1100 pc=%h", prog_req, rom_en, phase, rom_addr[0], prog_addr, mpc);
      else passed++;
      for (int i = 0; i < waits; i++) begin
         prog_ack = 0; prog_data = ~d; ctrl = cf; alu_carry = ~ac; alu_zero = ~az;
         @(negedge clk);
         total++;
         if ({prog_req, rom_en, phase, rom_addr[0], prog_addr, flags} !== {4'b1100, mpc, mflags})
            $display("FAIL fetch_wait got req/en/ph/ra0=%b%b%b%b pc=%h fl=%b want 1100 pc=%h fl=%b", prog_req, rom_en, phase, rom_addr[0], prog_addr, flags, mpc, mflags);
         else passed++;
      end
      prog_ack = 1; prog_data = d; ctrl = cf; alu_carry = ~ac; alu_zero = ~az;
      if (cf[12]) mpc++;
      sb.push_back('{mpc, d[3:0], {d[7:4], mflags, 1'b1}, mflags});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({prog_addr, operand, rom_addr, flags, phase, prog_req, rom_en} !== {e.pc, e.opr, e.ra, e.fl, 3'b101})
         $display("FAIL exec got pc=%h opr=%h ra=%b fl=%b ph/req/en=%b%b%b want pc=%h opr=%h ra=%b fl=%b 101", prog_addr, operand, rom_addr, flags, phase, prog_req, rom_en, e.pc, e.opr, e.ra, e.fl);
      else passed++;
      prog_ack = noise; prog_data = ~d; ctrl = ce; jump_addr = ja; alu_carry = ac; alu_zero = az;
      if (ce[11]) mpc = ja;
      else if (ce[12]) mpc++;
      if (ce[9]) mflags = {ac, az};
      sb.push_back('{mpc, d[3:0], 7'b0, mflags});
      @(negedge clk);
      e = sb.pop_front();
      prog_ack = 0;
      total++;
      if ({prog_addr, operand, flags} !== {e.pc, e.opr, e.fl})
         $display("FAIL exec_exit got pc=%h opr=%h fl=%b want pc=%h opr=%h fl=%b", prog_addr, operand, flags, e.pc, e.opr, e.fl);
      else passed++;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({prog_req, rom_en, phase, rom_addr, prog_addr, flags, operand} !== '0)
         $display("FAIL reset_hold got req=%b en=%b ph=%b ra=%b pc=%h fl=%b opr=%h want all 0", prog_req, rom_en, phase, rom_addr, prog_addr, flags, operand);
      else passed++;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({prog_req, rom_en, phase, prog_addr, flags} !== '0)
            $display("FAIL idle got req=%b en=%b ph=%b pc=%h fl=%b want 0 0 0 000 00", prog_req, rom_en, phase, prog_addr, flags);
         else passed++;
      end
      run = 1;
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      do_instr(8'h75, 0, 13'h1008, 13'h0000, 12'h000, 0, 0, 0);
   endtask

   task automatic test_wait_states();
      do_instr(8'h3A, 3, 13'h1000, 13'h0000, 12'h000, 0, 0, 0);
   endtask

   task automatic test_jump_wrap();
      do_instr(8'h21, 0, 13'h0000, 13'h1800, 12'h0A3, 0, 0, 0);
      do_instr(8'h22, 0, 13'h0000, 13'h0800, 12'hFFF, 0, 0, 0);
      do_instr(8'h23, 0, 13'h1000, 13'h0000, 12'h000, 0, 0, 0);
      do_instr(8'h24, 0, 13'h0000, 13'h0800, 12'hFFF, 0, 0, 0);
      do_instr(8'h25, 1, 13'h0000, 13'h1000, 12'h123, 0, 0, 0);
   endtask

   task automatic test_flags();
      do_instr(8'h40, 0, 13'h0200, 13'h0200, 12'h000, 1, 0, 0);
      do_instr(8'h50, 0, 13'h0000, 13'h0000, 12'h000, 0, 1, 1);
      do_instr(8'h61, 0, 13'h0000, 13'h0200, 12'h000, 0, 1, 0);
      do_instr(8'h62, 0, 13'h0200, 13'h1000, 12'h000, 1, 1, 1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++)
         do_instr(8'($urandom), int'($urandom_range(0, 2)), 13'($urandom), 13'($urandom),
                  PC_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic test_run_stop();
      run = 0; prog_ack = 0;
      @(negedge clk);
      total++;
      if ({prog_req, rom_en, phase, prog_addr} !== {3'b110, mpc})
         $display("FAIL run_drop_fetch got req/en/ph=%b%b%b pc=%h want 110 pc=%h", prog_req, rom_en, phase, prog_addr, mpc);
      else passed++;
      prog_ack = 1; prog_data = 8'h9C; ctrl = 13'h0000;
      @(negedge clk);
      prog_ack = 0;
      total++;
      if ({phase, operand, rom_addr} !== {1'b1, 4'hC, 4'h9, mflags, 1'b1})
         $display("FAIL run_drop_exec got ph=%b opr=%h ra=%b want 1 c %b", phase, operand, rom_addr, {4'h9, mflags, 1'b1});
      else passed++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({prog_req, rom_en, phase, prog_addr} !== {3'b000, mpc})
            $display("FAIL run_drop_idle got req/en/ph=%b%b%b pc=%h want 000 pc=%h", prog_req, rom_en, phase, prog_addr, mpc);
         else passed++;
      end
      run = 1;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      do_instr(8'h11, 0, 13'h1000, 13'h0200, 12'h000, 1, 1, 0);
      #2 rst_n = 0;
      #1;
      total++;
      if ({prog_req, rom_en, prog_addr, flags, rom_addr} !== '0)
         $display("FAIL mid_reset got req=%b en=%b pc=%h fl=%b ra=%b want all 0", prog_req, rom_en, prog_addr, flags, rom_addr);
      else passed++;
      mpc = 0; mflags = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      do_instr(8'hE7, 1, 13'h1000, 13'h1000, 12'h000, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_jump_wrap();
      test_flags();
      test_back_to_back();
      test_run_stop();
      test_mid_reset();
      total++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
